// File: rtl/beagleg_pkg.sv
// Shared BeagleG backend definitions: FIFO geometry, SPI command codes and
// the enums used by the SPI command dispatcher.
package beagleg_pkg;

  localparam int FifoDepth         = 16;
  localparam int MotionSegmentBits = 64;

  localparam logic [7:0] CMD_STATUS     = 8'h01;
  localparam logic [7:0] CMD_WRITE_FIFO = 8'h02;
  localparam logic [7:0] CMD_FLUSH      = 8'h03;
  localparam logic [7:0] CMD_SET_ENABLE = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_GET_CHANNEL   = 3'd1,
    ST_WRITE_PAYLOAD = 3'd2,
    ST_GET_MASK      = 3'd3,
    ST_STATUS_STREAM = 3'd4,
    ST_DISCARD       = 3'd5
  } dispatch_state_e;

  // Bit positions inside the sticky error_flags register.
  typedef enum logic [1:0] {
    ERR_UNKNOWN_CMD = 2'd0,
    ERR_BAD_CHANNEL = 2'd1,
    ERR_OVERFLOW    = 2'd2,
    ERR_ABORTED     = 2'd3
  } error_bits_e;

endpackage

// File: rtl/spi_command_dispatcher_free_slot_calc.sv
// Per-channel free record slots (saturated to 0..255) and the minimum
// over enabled channels, which is what the host sees while idle.
module free_slot_calc #(
  parameter int NumChannels = 4,
  parameter int FifoDepth   = 16,
  parameter int RecordBytes = 8,
  parameter int LevelWidth  = 8
) (
  input  logic [NumChannels*LevelWidth-1:0] fifo_level,
  input  logic [NumChannels-1:0]            channel_enable,
  output logic [NumChannels-1:0][7:0]       free,
  output logic [7:0]                        min_free
);

  localparam int Shift = $clog2(RecordBytes);

  genvar gi;
  generate
    for (gi = 0; gi < NumChannels; gi++) begin : g_free
      logic [LevelWidth-1:0] level;
      logic [31:0]           used;
      logic [31:0]           avail;

      assign level = fifo_level[gi*LevelWidth +: LevelWidth];
      assign used  = 32'(level >> Shift);
      // A level beyond the nominal depth still reads as "no room".
      assign avail = (used >= 32'(FifoDepth)) ? 32'd0 : 32'(FifoDepth) - used;
      assign free[gi] = (avail > 32'd255) ? 8'hFF : avail[7:0];
    end
  endgenerate

  logic [7:0] min_run;
  logic       any_enabled;

  always_comb begin
    min_run     = 8'hFF;
    any_enabled = 1'b0;
    for (int k = 0; k < NumChannels; k++) begin
      if (channel_enable[k]) begin
        any_enabled = 1'b1;
        if (free[k] < min_run) min_run = free[k];
      end
    end
    min_free = any_enabled ? min_run : 8'h00;
  end

endmodule

// File: rtl/spi_command_dispatcher.sv
// SPI command decoder: channel-addressed record writes, per-channel flush,
// enable mask, status readback and sticky protocol error flags.
module spi_command_dispatcher
  import beagleg_pkg::*;
#(
  parameter int NumChannels = 4,
  parameter int FifoDepth   = beagleg_pkg::FifoDepth,
  parameter int RecordBytes = beagleg_pkg::MotionSegmentBits / 8,
  parameter int LevelWidth  = $clog2(FifoDepth * RecordBytes) + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              spi_cs,
  input  logic [7:0]                        rx_byte,
  input  logic                              rx_valid,
  output logic [7:0]                        tx_byte,
  input  logic [NumChannels*LevelWidth-1:0] fifo_level,
  output logic [NumChannels-1:0]            fifo_write_en,
  output logic [7:0]                        fifo_data,
  output logic [NumChannels-1:0]            fifo_flush,
  output logic [NumChannels-1:0]            channel_enable,
  output logic [3:0]                        error_flags
);

  localparam int ChWidth    = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int CountWidth = (RecordBytes > 1) ? $clog2(RecordBytes) : 1;
  localparam int IdxWidth   = 4;

  dispatch_state_e         state_reg, state_next;
  logic                    write_mode_reg, write_mode_next;
  logic [ChWidth-1:0]      ch_reg, ch_next;
  logic [CountWidth-1:0]   count_reg, count_next;
  logic                    drop_reg, drop_next;
  logic [IdxWidth-1:0]     idx_reg, idx_next;
  logic [7:0]              tx_reg, tx_next;
  logic [NumChannels-1:0]  write_en_reg, write_en_next;
  logic [7:0]              data_reg, data_next;
  logic [NumChannels-1:0]  flush_reg, flush_next;
  logic [NumChannels-1:0]  enable_reg, enable_next;
  logic [3:0]              err_reg, err_next;

  logic [NumChannels-1:0][7:0] free;
  logic [7:0]                  min_free;
  logic [3:0]                  set_bits;
  logic                        clear_err;
  logic                        ch_ok;
  logic [IdxWidth-1:0]         idx_step;

  free_slot_calc #(
    .NumChannels(NumChannels),
    .FifoDepth  (FifoDepth),
    .RecordBytes(RecordBytes),
    .LevelWidth (LevelWidth)
  ) u_free_slot_calc (
    .fifo_level    (fifo_level),
    .channel_enable(enable_reg),
    .free          (free),
    .min_free      (min_free)
  );

  assign ch_ok = (rx_byte < 8'(NumChannels)) && enable_reg[rx_byte[ChWidth-1:0]];
  assign idx_step = (idx_reg <= IdxWidth'(NumChannels)) ? idx_reg + 1'b1 : idx_reg;

  always_comb begin
    state_next      = state_reg;
    write_mode_next = write_mode_reg;
    ch_next         = ch_reg;
    count_next      = count_reg;
    drop_next       = drop_reg;
    idx_next        = idx_reg;
    tx_next         = tx_reg;
    write_en_next   = '0;
    data_next       = data_reg;
    flush_next      = '0;
    enable_next     = enable_reg;
    set_bits        = 4'b0000;
    clear_err       = 1'b0;

    if (spi_cs) begin
      // Deselect wins over any same-cycle byte; a half-written record is purged.
      state_next = ST_IDLE;
      count_next = '0;
      idx_next   = '0;
      drop_next  = 1'b0;
      tx_next    = min_free;
      if (state_reg == ST_WRITE_PAYLOAD && count_reg != '0 && !drop_reg) begin
        flush_next[ch_reg]    = 1'b1;
        set_bits[ERR_ABORTED] = 1'b1;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          tx_next = min_free;
          if (rx_valid) begin
            tx_next = 8'h00;
            case (rx_byte)
              CMD_STATUS: begin
                state_next = ST_STATUS_STREAM;
                idx_next   = '0;
                tx_next    = free[0];
              end
              CMD_WRITE_FIFO: begin
                state_next      = ST_GET_CHANNEL;
                write_mode_next = 1'b1;
              end
              CMD_FLUSH: begin
                state_next      = ST_GET_CHANNEL;
                write_mode_next = 1'b0;
              end
              CMD_SET_ENABLE: state_next = ST_GET_MASK;
              default: begin
                state_next                = ST_DISCARD;
                set_bits[ERR_UNKNOWN_CMD] = 1'b1;
              end
            endcase
          end
        end

        ST_GET_CHANNEL: begin
          if (rx_valid) begin
            if (!ch_ok) begin
              set_bits[ERR_BAD_CHANNEL] = 1'b1;
              state_next                = ST_DISCARD;
            end else if (!write_mode_reg) begin
              flush_next[rx_byte[ChWidth-1:0]] = 1'b1;
              state_next                       = ST_DISCARD;
            end else begin
              ch_next    = rx_byte[ChWidth-1:0];
              count_next = '0;
              drop_next  = 1'b0;
              state_next = ST_WRITE_PAYLOAD;
            end
          end
        end

        ST_WRITE_PAYLOAD: begin
          if (rx_valid) begin
            // Room is judged once per record, on its first byte.
            if (count_reg == '0) begin
              drop_next = (free[ch_reg] == 8'h00);
              if (free[ch_reg] == 8'h00) set_bits[ERR_OVERFLOW] = 1'b1;
            end
            if ((count_reg == '0) ? (free[ch_reg] != 8'h00) : !drop_reg) begin
              write_en_next[ch_reg] = 1'b1;
              data_next             = rx_byte;
            end
            count_next = (count_reg == CountWidth'(RecordBytes - 1)) ? '0 : count_reg + 1'b1;
          end
        end

        ST_GET_MASK: begin
          if (rx_valid) begin
            enable_next = rx_byte[NumChannels-1:0];
            state_next  = ST_DISCARD;
          end
        end

        ST_STATUS_STREAM: begin
          if (rx_valid) begin
            idx_next = idx_step;
            if (idx_step < IdxWidth'(NumChannels)) begin
              tx_next = free[idx_step[ChWidth-1:0]];
            end else if (idx_step == IdxWidth'(NumChannels)) begin
              tx_next   = {4'b0000, err_reg};
              clear_err = 1'b1;
            end else begin
              tx_next = 8'h00;
            end
          end
        end

        default: tx_next = 8'h00;
      endcase
    end

    err_next = (clear_err ? 4'b0000 : err_reg) | set_bits;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      write_mode_reg <= 1'b0;
      ch_reg         <= '0;
      count_reg      <= '0;
      drop_reg       <= 1'b0;
      idx_reg        <= '0;
      tx_reg         <= 8'h00;
      write_en_reg   <= '0;
      data_reg       <= 8'h00;
      flush_reg      <= '0;
      enable_reg     <= '1;
      err_reg        <= 4'b0000;
    end else begin
      state_reg      <= state_next;
      write_mode_reg <= write_mode_next;
      ch_reg         <= ch_next;
      count_reg      <= count_next;
      drop_reg       <= drop_next;
      idx_reg        <= idx_next;
      tx_reg         <= tx_next;
      write_en_reg   <= write_en_next;
      data_reg       <= data_next;
      flush_reg      <= flush_next;
      enable_reg     <= enable_next;
      err_reg        <= err_next;
    end
  end

  assign tx_byte        = tx_reg;
  assign fifo_write_en  = write_en_reg;
  assign fifo_data      = data_reg;
  assign fifo_flush     = flush_reg;
  assign channel_enable = enable_reg;
  assign error_flags    = err_reg;

endmodule

// File: tb/tb_spi_command_dispatcher.sv
// Directed bench for spi_command_dispatcher: stimulus pushes expected tx bytes,
// write strobes and flush pulses into queues; a monitor pops and compares.
module tb_spi_command_dispatcher;
  import beagleg_pkg::*;

  localparam int N  = 4;
  localparam int FD = 16;
  localparam int RB = 8;
  localparam int LW = 8;

  logic            clk;
  logic            rst;
  logic            spi_cs;
  logic [7:0]      rx_byte;
  logic            rx_valid;
  logic [7:0]      tx_byte;
  logic [N*LW-1:0] fifo_level;
  logic [N-1:0]    fifo_write_en;
  logic [7:0]      fifo_data;
  logic [N-1:0]    fifo_flush;
  logic [N-1:0]    channel_enable;
  logic [3:0]      error_flags;

  spi_command_dispatcher #(
    .NumChannels(N), .FifoDepth(FD), .RecordBytes(RB), .LevelWidth(LW)
  ) dut (
    .clk(clk), .rst(rst), .spi_cs(spi_cs), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .fifo_level(fifo_level), .fifo_write_en(fifo_write_en),
    .fifo_data(fifo_data), .fifo_flush(fifo_flush), .channel_enable(channel_enable),
    .error_flags(error_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [11:0] exp_wr[$];
  logic [3:0]  exp_fl[$];
  logic [7:0]  exp_tx[$];
  logic        rx_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    total_cnt++;
    $display("FAIL %s: got 0x%0h, required no event", name, act);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(posedge clk) rx_q <= rx_valid & ~spi_cs & ~rst;

  always @(negedge clk) begin
    if (rx_q) begin
      if (exp_tx.size() == 0) unexpected("tx_byte", 32'(tx_byte));
      else check("tx_byte", 32'(tx_byte), 32'(exp_tx.pop_front()));
    end
    if (fifo_write_en != '0) begin
      if (exp_wr.size() == 0) unexpected("write", 32'({fifo_write_en, fifo_data}));
      else check("write", 32'({fifo_write_en, fifo_data}), 32'(exp_wr.pop_front()));
    end
    if (fifo_flush != '0) begin
      if (exp_fl.size() == 0) unexpected("flush", 32'(fifo_flush));
      else check("flush", 32'(fifo_flush), 32'(exp_fl.pop_front()));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic set_levels(input logic [7:0] l0, input logic [7:0] l1,
                            input logic [7:0] l2, input logic [7:0] l3);
    fifo_level = {l3, l2, l1, l0};
  endtask

  task automatic send(input logic [7:0] b, input logic [7:0] e);
    @(posedge clk); #1;
    rx_byte  = b;
    rx_valid = 1'b1;
    exp_tx.push_back(e);
    $display("send 0x%02h expect tx 0x%02h", b, e);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic end_txn();
    @(posedge clk); #1;
    spi_cs = 1'b1;
    repeat (3) @(posedge clk);
    #1 spi_cs = 1'b0;
  endtask

  task automatic idle_wait();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; spi_cs = 1'b1; rx_byte = 8'h00; rx_valid = 1'b0;
    set_levels(8'd0, 8'd16, 8'd128, 8'd64);
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", 32'(tx_byte), 32'h00);
    check("rst_wen", 32'(fifo_write_en), 32'h0);
    check("rst_flush", 32'(fifo_flush), 32'h0);
    check("rst_data", 32'(fifo_data), 32'h00);
    check("rst_enable", 32'(channel_enable), 32'hF);
    check("rst_err", 32'(error_flags), 32'h0);
    rst = 1'b0;

    // Idle min-free: {16,14,8,8} -> 8, then {16,14,0,8} -> 0.
    set_levels(8'd0, 8'd16, 8'd64, 8'd64);
    idle_wait();
    check("idle_min", 32'(tx_byte), 32'd8);
    set_levels(8'd0, 8'd16, 8'd128, 8'd64);
    idle_wait();
    check("idle_min_zero", 32'(tx_byte), 32'd0);

    // Status readback.
    spi_cs = 1'b0;
    send(CMD_STATUS, 8'd16);
    send(8'h00, 8'd14);
    send(8'h00, 8'd0);
    send(8'h00, 8'd8);
    send(8'h00, 8'h00);
    send(8'h00, 8'h00);
    end_txn();

    // Two back-to-back records to channel 2.
    set_levels(8'd0, 8'd0, 8'd0, 8'd0);
    send(CMD_WRITE_FIFO, 8'h00);
    send(8'd2, 8'h00);
    for (int i = 0; i < 16; i++) begin
      exp_wr.push_back({4'b0100, 8'(8'h10 + i)});
      send(8'(8'h10 + i), 8'h00);
    end
    end_txn();
    check("write_err", 32'(error_flags), 32'h0);

    // Overflow on full channel 1.
    set_levels(8'd0, 8'd128, 8'd0, 8'd0);
    send(CMD_WRITE_FIFO, 8'h00);
    send(8'd1, 8'h00);
    for (int i = 0; i < 8; i++) send(8'(8'hA0 + i), 8'h00);
    end_txn();
    check("ovf_err", 32'(error_flags), 32'h4);
    send(CMD_STATUS, 8'd16);
    send(8'h00, 8'd0);
    send(8'h00, 8'd16);
    send(8'h00, 8'd16);
    send(8'h00, 8'h04);
    end_txn();
    check("ovf_err_clear", 32'(error_flags), 32'h0);

    // Abort after 3 of 8 bytes to channel 0.
    set_levels(8'd0, 8'd0, 8'd0, 8'd0);
    send(CMD_WRITE_FIFO, 8'h00);
    send(8'd0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      exp_wr.push_back({4'b0001, 8'(8'h50 + i)});
      send(8'(8'h50 + i), 8'h00);
    end
    exp_fl.push_back(4'b0001);
    end_txn();
    check("abort_err", 32'(error_flags), 32'h8);
    idle_wait();
    check("abort_idle_tx", 32'(tx_byte), 32'd16);
    send(CMD_STATUS, 8'd16);
    send(8'h00, 8'd16);
    send(8'h00, 8'd16);
    send(8'h00, 8'd16);
    send(8'h00, 8'h08);
    end_txn();
    check("abort_err_clear", 32'(error_flags), 32'h0);

    // Enable mask, disabled and out-of-range channels, flush, unknown command.
    send(CMD_SET_ENABLE, 8'h00);
    send(8'h05, 8'h00);
    end_txn();
    check("enable_mask", 32'(channel_enable), 32'h5);
    send(CMD_WRITE_FIFO, 8'h00);
    send(8'd1, 8'h00);
    send(8'hAA, 8'h00);
    end_txn();
    check("disabled_err", 32'(error_flags), 32'h2);
    send(CMD_STATUS, 8'd16);
    send(8'h00, 8'd16);
    send(8'h00, 8'd16);
    send(8'h00, 8'd16);
    send(8'h00, 8'h02);
    end_txn();
    check("disabled_clear", 32'(error_flags), 32'h0);
    send(CMD_WRITE_FIFO, 8'h00);
    send(8'd7, 8'h00);
    send(8'hBB, 8'h00);
    end_txn();
    check("badch_err", 32'(error_flags), 32'h2);
    exp_fl.push_back(4'b0100);
    send(CMD_FLUSH, 8'h00);
    send(8'd2, 8'h00);
    end_txn();
    send(8'hEE, 8'h00);
    end_txn();
    check("unknown_err", 32'(error_flags), 32'h3);

    // Reset in the middle of a record: no flush, everything back to reset values.
    send(CMD_WRITE_FIFO, 8'h00);
    send(8'd0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      exp_wr.push_back({4'b0001, 8'(8'h70 + i)});
      send(8'(8'h70 + i), 8'h00);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_tx", 32'(tx_byte), 32'h00);
    check("mid_rst_data", 32'(fifo_data), 32'h00);
    check("mid_rst_enable", 32'(channel_enable), 32'hF);
    check("mid_rst_err", 32'(error_flags), 32'h0);
    spi_cs = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_tx", 32'(tx_byte), 32'd16);

    check("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
    check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    check("fl_queue_drained", 32'(exp_fl.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/spi_command_dispatcher.md
# spi_command_dispatcher

Parametrised SPI command decoder for the FPGA backend. It sits between `spi_secondary` and a bank of `NumChannels` motion-segment FIFOs. It replaces the single-FIFO two-state command FSM with channel-addressed writes, per-channel flush, a channel enable mask, per-channel status readback and sticky protocol error flags.

## Interface
Parameters:
- `NumChannels`, default 4: number of downstream FIFOs (1..8).
- `FifoDepth`, default `beagleg_pkg::FifoDepth`: records per FIFO.
- `RecordBytes`, default `beagleg_pkg::MotionSegmentBits/8`: bytes per record; must be a power of two.
- `LevelWidth`, default `$clog2(FifoDepth*RecordBytes)+1`: width of each FIFO level input.

Ports (one clock, `clk`; reset `rst` is asynchronous, active-high):
- `clk` in 1: system clock.
- `rst` in 1: async active-high reset.
- `spi_cs` in 1: chip select, active low (1 = deselected).
- `rx_byte` in 8: byte received from host.
- `rx_valid` in 1: one-cycle pulse, `rx_byte` valid.
- `tx_byte` out 8: byte `spi_secondary` shifts out next.
- `fifo_level` in `NumChannels*LevelWidth`: per-channel occupancy in bytes, channel 0 in the LSBs.
- `fifo_write_en` out `NumChannels`: one-hot byte write strobe.
- `fifo_data` out 8: write data, shared by all channels.
- `fifo_flush` out `NumChannels`: one-cycle flush pulse per channel.
- `channel_enable` out `NumChannels`: enable mask register.
- `error_flags` out 4: sticky errors. Bit0 unknown cmd, bit1 bad/disabled channel, bit2 overflow, bit3 aborted record.

## Operation
Free slots per channel:
- `free[k] = FifoDepth - (level[k] >> log2(RecordBytes))`, saturated to 0..255.

Each transaction starts with a command byte.

States: IDLE, GET_CHANNEL, WRITE_PAYLOAD, GET_MASK, STATUS_STREAM, DISCARD.

IDLE:
- `tx_byte` = minimum `free[k]` over enabled channels; 0 if none are enabled.
- On `rx_valid`:
  - CMD_STATUS -> STATUS_STREAM, index 0.
  - CMD_WRITE_FIFO -> GET_CHANNEL (write mode).
  - CMD_FLUSH -> GET_CHANNEL (flush mode).
  - CMD_SET_ENABLE -> GET_MASK.
  - Anything else -> DISCARD, set bit0.

GET_CHANNEL, on `rx_valid`:
- Byte ≥ `NumChannels`, or the channel is disabled: set bit1, -> DISCARD.
- Flush mode: pulse `fifo_flush[ch]`, -> DISCARD.
- Write mode: latch `ch`, byte counter = 0, -> WRITE_PAYLOAD.

WRITE_PAYLOAD:
- At counter 0, evaluate `free[ch]`. If it is 0, set bit2 and drop the whole record (drop flag held until the counter wraps).
- Otherwise forward each byte: `fifo_write_en[ch]=1`, `fifo_data=rx_byte`.
- The counter wraps at `RecordBytes`, so back-to-back records are accepted until `spi_cs` rises.

GET_MASK:
- On `rx_valid`, `channel_enable <= rx_byte[NumChannels-1:0]`, -> DISCARD.

STATUS_STREAM:
- `tx_byte` sequence: `free[0]`, then `free[1]` … `free[N-1]`, then `{4'b0,error_flags}`, then 0x00 repeated.
- Each `rx_valid` advances the index.
- When the error byte is loaded, `error_flags` clears, except bits set in that same cycle.

DISCARD:
- Ignore bytes; `tx_byte` = 0x00.

`spi_cs`=1 (synchronous, every cycle):
- -> IDLE, counters cleared. This has priority over a same-cycle `rx_valid`.
- If the state was WRITE_PAYLOAD, the counter ≠ 0 and the record was not dropped: pulse `fifo_flush[ch]` and set bit3. Partial records never remain in a FIFO.

## Timing
- Reset values:
  - state IDLE.
  - `tx_byte` 0x00; IDLE value is valid from the first cycle after reset.
  - `fifo_write_en` 0, `fifo_flush` 0, `fifo_data` 0x00.
  - `channel_enable` all ones.
  - `error_flags` 0.
- All outputs are registered.
- `fifo_write_en`/`fifo_data` and `fifo_flush` assert exactly 1 cycle after the triggering `rx_valid` (or after `spi_cs` rises) and last 1 cycle.
- `tx_byte` updates 1 cycle after `rx_valid`.
- `spi_secondary` guarantees ≥16 clk between `rx_valid` pulses.
- `free[k]` is sampled combinationally from `fifo_level` in the cycle of the first byte of each record.
- Mid-operation reset: all outputs return to reset values immediately. No flush is issued.

## Structure
- `beagleg_pkg` gains:
  - CMD_FLUSH and CMD_SET_ENABLE, alongside existing CMD_STATUS and CMD_WRITE_FIFO.
  - A `dispatch_state_e` enum.
  - An `error_bits_e` bit-index enum.
- Sub-module `free_slot_calc`: per-channel `free[k]` computation, saturation and the enabled-minimum reduction. Parametrised on `NumChannels`, `FifoDepth`, `RecordBytes`.

## Test plan
- **Status readback:** N=4, RecordBytes=8, levels {0,16,128,64}, FifoDepth=16. Send CMD_STATUS then 6 bytes -> `tx_byte` reads 16,14,0,8,0x00,0x00. The IDLE `tx_byte` was 0.
- **Write two records:** CMD_WRITE_FIFO, ch 2, 16 payload bytes 0x10..0x1F -> `fifo_write_en`=4'b0100 for 16 single-cycle pulses, data in order, no flags.
- **Overflow:** ch1 level = 128 (full), write one record -> no write strobes, `error_flags`=4'b0100. Next CMD_STATUS stream returns 0x04 at index 4 and the flags clear.
- **Abort mid-record:** raise `spi_cs` after 3 of 8 bytes to ch0 -> one `fifo_flush`=4'b0001 pulse, bit3 set, state IDLE.
- **Bad and disabled channels:** CMD_SET_ENABLE 0x05, then write to ch1 -> bit1 set, no writes. Write to ch7 -> bit1, no writes. CMD_FLUSH ch2 -> `fifo_flush`=4'b0100.
- **Reset during payload:** assert `rst` mid-record -> outputs at reset values same cycle, no flush, mask 4'b1111.
